// File: rtl/sort_pkg.sv
// Shared constants and helpers for the pipelined rank sorter.
// Mode encoding is sampled per vector and travels with it.
package sort_pkg;

    localparam int SORT_W_DATA = 8;
    localparam int SORT_NUM    = 32;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    function automatic int sort_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sort_rank_row.sv
// One row of the pairwise flag matrix: which elements element J beats.
// The index tie-break keeps equal values in input order in both modes.
module sort_rank_row
    import sort_pkg::*;
#(
    parameter int W_DATA = SORT_W_DATA,
    parameter int NUM    = SORT_NUM,
    parameter int J      = 0
) (
    input  logic [W_DATA-1:0]     elem_i,
    input  logic [NUM*W_DATA-1:0] vec_i,
    input  logic                  mode_i,
    output logic [NUM-1:0]        gt_o
);

    always_comb begin
        gt_o = '0;
        for (int i = 0; i < NUM; i++) begin
            if (mode_i == SORT_DESC) begin
                gt_o[i] = (elem_i < vec_i[i*W_DATA +: W_DATA]) ||
                          ((elem_i == vec_i[i*W_DATA +: W_DATA]) && (J > i));
            end else begin
                gt_o[i] = (elem_i > vec_i[i*W_DATA +: W_DATA]) ||
                          ((elem_i == vec_i[i*W_DATA +: W_DATA]) && (J > i));
            end
        end
    end

endmodule

// File: rtl/sort_rank_pipe.sv
// Three-stage rank sorter: compare, popcount rank, scatter to slots.
// Valid/ready chain lets each stage refill as soon as its successor moves.
module sort_rank_pipe
    import sort_pkg::*;
#(
    parameter int W_DATA = SORT_W_DATA,
    parameter int NUM    = SORT_NUM,
    parameter int W_IDX  = sort_clog2(NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic                  mode_desc,
    input  logic [NUM*W_DATA-1:0] din,
    output logic                  vld_out,
    input  logic                  rdy_out,
    output logic [NUM*W_DATA-1:0] dout,
    output logic [NUM*W_IDX-1:0]  idx_out
);

    logic [NUM*NUM-1:0]    gt_d;
    logic                  s1_vld_q;
    logic [NUM*W_DATA-1:0] s1_data_q;
    logic [NUM*NUM-1:0]    s1_gt_q;
    logic                  s2_vld_q;
    logic [NUM*W_DATA-1:0] s2_data_q;
    logic [NUM*W_IDX-1:0]  s2_rank_q;
    logic [NUM*W_IDX-1:0]  rank_d;
    logic                  out_vld_q;
    logic [NUM*W_DATA-1:0] dout_q;
    logic [NUM*W_DATA-1:0] dout_d;
    logic [NUM*W_IDX-1:0]  idx_q;
    logic [NUM*W_IDX-1:0]  idx_d;
    logic                  out_adv;
    logic                  s2_adv;
    logic                  s1_adv;

    for (genvar j = 0; j < NUM; j++) begin : g_row
        sort_rank_row #(
            .W_DATA (W_DATA),
            .NUM    (NUM),
            .J      (j)
        ) u_row (
            .elem_i (din[j*W_DATA +: W_DATA]),
            .vec_i  (din),
            .mode_i (mode_desc),
            .gt_o   (gt_d[j*NUM +: NUM])
        );
    end

    assign out_adv = !out_vld_q || rdy_out;
    assign s2_adv  = !s2_vld_q || out_adv;
    assign s1_adv  = !s1_vld_q || s2_adv;
    assign rdy_in  = s1_adv;

    assign vld_out = out_vld_q;
    assign dout    = dout_q;
    assign idx_out = idx_q;

    always_comb begin
        rank_d = '0;
        for (int j = 0; j < NUM; j++) begin
            for (int i = 0; i < NUM; i++) begin
                rank_d[j*W_IDX +: W_IDX] = rank_d[j*W_IDX +: W_IDX] +
                                           W_IDX'(s1_gt_q[j*NUM + i]);
            end
        end
    end

    // Ranks are a permutation, so every slot is written exactly once.
    always_comb begin
        dout_d = '0;
        idx_d  = '0;
        for (int j = 0; j < NUM; j++) begin
            dout_d[int'(s2_rank_q[j*W_IDX +: W_IDX])*W_DATA +: W_DATA] =
                s2_data_q[j*W_DATA +: W_DATA];
            idx_d[int'(s2_rank_q[j*W_IDX +: W_IDX])*W_IDX +: W_IDX] =
                W_IDX'(j);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_gt_q   <= '0;
        end else if (s1_adv) begin
            s1_vld_q <= vld_in;
            if (vld_in) begin
                s1_data_q <= din;
                s1_gt_q   <= gt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_rank_q <= '0;
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_data_q <= s1_data_q;
                s2_rank_q <= rank_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            idx_q     <= '0;
        end else if (out_adv) begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                dout_q <= dout_d;
                idx_q  <= idx_d;
            end
        end
    end

endmodule

// File: tb/tb_sort_rank_pipe.sv
// Directed bench for sort_rank_pipe: ordering, ties, stalls, reset
// and a small odd-sized instance.
module tb_sort_rank_pipe;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int WI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic           vld_in, rdy_in, mode_desc, vld_out, rdy_out;
    logic [N*W-1:0] din, dout;
    logic [N*WI-1:0] idx_out;

    logic        v5_in, r5_in, m5, v5_out, r5_out;
    logic [79:0] d5_in, d5_out;
    logic [14:0] i5_out;

    int errs = 0;
    int checks = 0;

    sort_rank_pipe #(.W_DATA(W), .NUM(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (vld_in),
        .rdy_in    (rdy_in),
        .mode_desc (mode_desc),
        .din       (din),
        .vld_out   (vld_out),
        .rdy_out   (rdy_out),
        .dout      (dout),
        .idx_out   (idx_out)
    );

    sort_rank_pipe #(.W_DATA(16), .NUM(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (v5_in),
        .rdy_in    (r5_in),
        .mode_desc (m5),
        .din       (d5_in),
        .vld_out   (v5_out),
        .rdy_out   (r5_out),
        .dout      (d5_out),
        .idx_out   (i5_out)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] ramp_d(input int a, input int b);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(a + b*k);
        return r;
    endfunction

    function automatic logic [159:0] ramp_i(input int a, input int b);
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*WI +: WI] = WI'(a + b*k);
        return r;
    endfunction

    function automatic logic [255:0] bp_din(input int v);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'((k + 7*v) % N);
        return r;
    endfunction

    function automatic logic [255:0] bp_dout(input int v);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[k*W +: W] = W'((v % 2 == 1) ? (N - 1 - k) : k);
        return r;
    endfunction

    function automatic logic [159:0] bp_idx(input int v);
        logic [159:0] r;
        int s;
        r = '0;
        for (int k = 0; k < N; k++) begin
            s = (v % 2 == 1) ? (N - 1 - k) : k;
            r[k*WI +: WI] = WI'((s - 7*v + 7*N) % N);
        end
        return r;
    endfunction

    task automatic run_one(input string tag, input logic [255:0] d,
                           input logic m, input logic [255:0] ed,
                           input logic [159:0] ei);
        din = d;
        mode_desc = m;
        vld_in = 1'b1;
        rdy_out = 1'b1;
        #1;
        check({tag, "_rdy"}, rdy_in, 1);
        tick();
        vld_in = 1'b0;
        check({tag, "_lat1"}, vld_out, 0);
        tick();
        check({tag, "_lat2"}, vld_out, 0);
        tick();
        check({tag, "_vld"}, vld_out, 1);
        check({tag, "_dout"}, dout, ed);
        check({tag, "_idx"}, idx_out, ei);
        tick();
        check({tag, "_drain"}, vld_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, recv, low;
        logic acc;
        vld_in = 0; mode_desc = 0; rdy_out = 1; din = '0;
        v5_in = 0; m5 = 0; r5_out = 1; d5_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_vld", vld_out, 0);
        check("rst_dout", dout, 0);
        check("rst_idx", idx_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_rdy", rdy_in, 1);
        check("rst_rdy5", r5_in, 1);

        run_one("rev", ramp_d(31, -1), 1'b0, ramp_d(0, 1), ramp_i(31, -1));
        run_one("tie_asc", ramp_d(85, 0), 1'b0, ramp_d(85, 0), ramp_i(0, 1));
        run_one("tie_desc", ramp_d(85, 0), 1'b1, ramp_d(85, 0), ramp_i(0, 1));

        din = ramp_d(0, 8); mode_desc = 1'b1; vld_in = 1'b1; rdy_out = 1'b1;
        tick();
        mode_desc = 1'b0;
        tick();
        vld_in = 1'b0;
        check("mode_lat", vld_out, 0);
        tick();
        check("mode_a_vld", vld_out, 1);
        check("mode_a_dout", dout, ramp_d(248, -8));
        check("mode_a_idx", idx_out, ramp_i(31, -1));
        tick();
        check("mode_b_vld", vld_out, 1);
        check("mode_b_dout", dout, ramp_d(0, 8));
        check("mode_b_idx", idx_out, ramp_i(0, 1));
        tick();
        check("mode_drain", vld_out, 0);

        sent = 0; recv = 0; low = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            rdy_out = !(c >= 3 && c <= 9);
            vld_in = (sent < 6);
            din = bp_din(sent);
            mode_desc = (sent % 2 == 1);
            #1;
            if (vld_out) begin
                check("bp_dout", dout, bp_dout(recv));
                check("bp_idx", idx_out, bp_idx(recv));
                if (rdy_out) recv++;
            end
            if (!rdy_in) low++;
            if (c == 3) check("bp_rdy_c3", rdy_in, 0);
            acc = vld_in && rdy_in;
            tick();
            if (acc) sent++;
        end
        vld_in = 1'b0;
        rdy_out = 1'b1;
        check("bp_recv", recv, 6);
        check("bp_sent", sent, 6);
        check("bp_low", low, 7);
        check("bp_drain", vld_out, 0);

        din = ramp_d(31, -1); mode_desc = 1'b0; vld_in = 1'b1;
        tick();
        din = bp_din(1);
        tick();
        vld_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_vld", vld_out, 0);
        check("mid_dout", dout, 0);
        check("mid_idx", idx_out, 0);
        #2 rst_n = 1'b1;
        #1;
        check("mid_rdy", rdy_in, 1);
        run_one("post_rst", bp_din(2), 1'b0, bp_dout(2), bp_idx(2));

        d5_in = {16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF};
        m5 = 1'b0; v5_in = 1'b1; r5_out = 1'b1;
        tick();
        v5_in = 1'b0;
        check("n5_lat1", v5_out, 0);
        tick();
        tick();
        check("n5_vld", v5_out, 1);
        check("n5_dout", d5_out,
              {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000});
        check("n5_idx", i5_out, {3'd0, 3'd2, 3'd4, 3'd3, 3'd1});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
